// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream demultiplexer.
package stream_pkg;

    // Packet-level demux state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } demux_state_e;

    // Select width that never collapses to zero bits.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready output register carrying data plus last.
module stream_reg_slice #(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             last_in,
    input  logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             last_out
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             last_q,  last_d;

    // Next-state: load wins over drain, payload only changes on load.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
            last_d  = last_in;
        end else if (ready_out) begin
            valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload is a plain register, not a memory, so it is reset
        // too; outputs must read zero immediately after reset.
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating together.
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign last_out  = last_q;

endmodule

// File: rtl/stream_demux.sv
// N-way packet demultiplexer: select is locked on the first beat of a packet,
// out-of-range selects are swallowed whole and counted.
module stream_demux
    import stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_CH  = 4,
    parameter  int CNT_W = 16,
    localparam int SEL_W = sel_width(N_CH)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    input  logic [SEL_W-1:0]      s_sel,
    input  logic                  s_last,
    output logic [N_CH-1:0]       m_valid,
    input  logic [N_CH-1:0]       m_ready,
    output logic [N_CH*WIDTH-1:0] m_data,
    output logic [N_CH-1:0]       m_last,
    output logic                  busy,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

    demux_state_e     state_q, state_d;
    logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [N_CH-1:0]  load;
    logic             sel_in_range;
    logic [SEL_W-1:0] sel_idx;

    // Clamp the live select so the channel lookup never goes out of range.
    assign sel_in_range = ({1'b0, s_sel} < N_CH_W);
    assign sel_idx      = sel_in_range ? s_sel : '0;

    // Next-state, input ready and per-channel load strobes.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        drop_cnt_d = drop_cnt_q;
        s_ready    = 1'b0;
        load       = '0;
        unique case (state_q)
            IDLE: begin
                s_ready = en & (~sel_in_range | ~m_valid[sel_idx] | m_ready[sel_idx]);
                if (s_valid && s_ready) begin
                    if (sel_in_range) begin
                        load[sel_idx] = 1'b1;
                        lock_sel_d    = sel_idx;
                        if (!s_last) state_d = ROUTE;
                    end else begin
                        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        if (!s_last) state_d = DROP;
                    end
                end
            end
            ROUTE: begin
                s_ready = ~m_valid[lock_sel_q] | m_ready[lock_sel_q];
                if (s_valid && s_ready) begin
                    load[lock_sel_q] = 1'b1;
                    if (s_last) state_d = IDLE;
                end
            end
            DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Packet state, locked select and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // One output register per channel; all share the input payload.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        stream_reg_slice #(.WIDTH(WIDTH)) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .data_in   (s_data),
            .last_in   (s_last),
            .ready_out (m_ready[k]),
            .valid_out (m_valid[k]),
            .data_out  (m_data[k*WIDTH +: WIDTH]),
            .last_out  (m_last[k])
        );
    end

    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: a 4-channel instance for routing and a
// 3-channel, 2-bit-counter instance for drops and saturation.
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    // 4-channel instance
    logic        en = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_ready, busy;
    logic [7:0]  s_data = '0;
    logic [1:0]  s_sel = '0;
    logic [3:0]  m_valid, m_last, m_ready = '0;
    logic [31:0] m_data;
    logic [15:0] drop_cnt;

    // 3-channel instance
    logic        d_en = 1'b1, d_s_valid = 1'b0, d_s_last = 1'b0, d_s_ready, d_busy;
    logic [7:0]  d_s_data = '0;
    logic [1:0]  d_s_sel = '0;
    logic [2:0]  d_m_valid, d_m_last, d_m_ready = '1;
    logic [23:0] d_m_data;
    logic [1:0]  d_drop_cnt;

    logic [8:0]  exp_q [4][$];

    stream_demux u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sel(s_sel), .s_last(s_last), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
        .drop_cnt(drop_cnt)
    );

    stream_demux #(.N_CH(3), .CNT_W(2)) u_drop (
        .clk(clk), .rst_n(rst_n), .en(d_en), .s_valid(d_s_valid), .s_ready(d_s_ready),
        .s_data(d_s_data), .s_sel(d_s_sel), .s_last(d_s_last), .m_valid(d_m_valid),
        .m_ready(d_m_ready), .m_data(d_m_data), .m_last(d_m_last), .busy(d_busy),
        .drop_cnt(d_drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake pops and compares the channel's queue.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_n && m_valid[k] && m_ready[k]) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("unexpected_ch%0d", k), {23'd0, m_last[k], m_data[k*8 +: 8]}, 32'h1ff);
                end else begin
                    check($sformatf("beat_ch%0d", k), {23'd0, m_last[k], m_data[k*8 +: 8]},
                          {23'd0, exp_q[k].pop_front()});
                end
            end
        end
    end

    // Offer one beat on the 4-channel instance; push its expectation on accept.
    task automatic send(input logic [7:0] data, input logic [1:0] sel, input logic last,
                        input int ch);
        bit done = 0;
        s_valid = 1'b1; s_data = data; s_sel = sel; s_last = last;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                exp_q[ch].push_back({last, data});
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    initial begin
        int c0;
        logic [1:0] exp_cnt;

        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_m_valid", {28'd0, m_valid}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 32'h0);
        @(posedge clk); #1;

        // 1: single-beat packet to ch2
        en = 1'b1; m_ready = 4'b1111;
        send(8'hA5, 2'd2, 1'b1, 2);
        check("t1_busy_after", {31'd0, busy}, 32'h0);
        @(negedge clk);
        check("t1_m_valid", {28'd0, m_valid}, 32'h4);
        check("t1_m_data2", {24'd0, m_data[23:16]}, 32'hA5);
        check("t1_m_last2", {31'd0, m_last[2]}, 32'h1);
        @(posedge clk); #1;

        // 2: select locked on first beat
        c0 = cyc;
        send(8'h11, 2'd1, 1'b0, 1);
        check("t2_busy_mid", {31'd0, busy}, 32'h1);
        send(8'h22, 2'd3, 1'b0, 1);
        send(8'h33, 2'd3, 1'b1, 1);
        check("t2_cycles", cyc - c0, 32'd3);
        check("t2_busy_end", {31'd0, busy}, 32'h0);
        @(posedge clk); #1;

        // 3: backpressure on ch0
        m_ready[0] = 1'b0;
        send(8'h40, 2'd0, 1'b0, 0);
        s_valid = 1'b1; s_data = 8'h41; s_sel = 2'd0; s_last = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t3_stall_ready", {31'd0, s_ready}, 32'h0);
            check("t3_stall_data", {24'd0, m_data[7:0]}, 32'h40);
            check("t3_stall_valid", {31'd0, m_valid[0]}, 32'h1);
            @(posedge clk); #1;
        end
        m_ready[0] = 1'b1;
        c0 = cyc;
        send(8'h41, 2'd0, 1'b0, 0);
        send(8'h42, 2'd0, 1'b0, 0);
        send(8'h43, 2'd0, 1'b1, 0);
        check("t3_cycles", cyc - c0, 32'd3);
        @(posedge clk); #1;

        // 5: enable gating and reset mid-packet
        en = 1'b0;
        s_valid = 1'b1; s_data = 8'h99; s_sel = 2'd0; s_last = 1'b1;
        @(negedge clk);
        check("t5_en_low_ready", {31'd0, s_ready}, 32'h0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        en = 1'b1;
        send(8'h50, 2'd2, 1'b0, 2);
        en = 1'b0;
        send(8'h51, 2'd2, 1'b0, 2);
        send(8'h52, 2'd2, 1'b1, 2);
        check("t5_en_mid_busy", {31'd0, busy}, 32'h0);
        @(posedge clk); #1;
        en = 1'b1; m_ready = 4'b0000;
        send(8'h60, 2'd1, 1'b0, 1);
        check("t5_pre_rst_busy", {31'd0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_m_valid", {28'd0, m_valid}, 32'h0);
        check("t5_rst_m_data", m_data, 32'h0);
        check("t5_rst_m_last", {28'd0, m_last}, 32'h0);
        check("t5_rst_busy", {31'd0, busy}, 32'h0);
        check("t5_rst_drop_cnt", {16'd0, drop_cnt}, 32'h0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        m_ready = 4'b1111;
        send(8'h77, 2'd0, 1'b1, 0);
        @(posedge clk); #1;

        // 4: drops on the 3-channel instance with a 2-bit counter
        d_s_valid = 1'b1; d_s_sel = 2'd3; d_s_data = 8'hEE; d_s_last = 1'b0;
        @(negedge clk);
        check("t4_ready_b1", {31'd0, d_s_ready}, 32'h1);
        @(posedge clk); #1;
        check("t4_busy_mid", {31'd0, d_busy}, 32'h1);
        check("t4_cnt_mid", {30'd0, d_drop_cnt}, 32'd1);
        d_s_last = 1'b1; d_s_sel = 2'd0;
        @(negedge clk);
        check("t4_ready_b2", {31'd0, d_s_ready}, 32'h1);
        @(posedge clk); #1;
        check("t4_busy_end", {31'd0, d_busy}, 32'h0);
        check("t4_cnt_end", {30'd0, d_drop_cnt}, 32'd1);
        check("t4_no_valid", {29'd0, d_m_valid}, 32'h0);
        exp_cnt = 2'd1;
        d_s_sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_sat_ready", {31'd0, d_s_ready}, 32'h1);
            @(posedge clk); #1;
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            check("t4_sat_cnt", {30'd0, d_drop_cnt}, {30'd0, exp_cnt});
        end
        d_s_valid = 1'b0;
        @(negedge clk);
        check("t4_final_cnt", {30'd0, d_drop_cnt}, 32'd3);
        check("t4_final_valid", {29'd0, d_m_valid}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("queues_empty",
              exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
